// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage memory-access engine.
// FSM state codes, lane-mask width, timeout default, RAM request bundle.
package mem_access_pkg;

  localparam int MEM_SEL_BUS         = 4;
  localparam int MEM_FSM_BUS         = 2;
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [MEM_FSM_BUS-1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_HOLD  = 2'd2,
    MEM_DRAIN = 2'd3
  } mem_fsm_t;

  typedef struct packed {
    logic [MEM_SEL_BUS-1:0] write_en;
    logic [31:0]            addr;
    logic [31:0]            write_data;
  } ram_req_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-RAM req/ack port of the MEM stage.
// master: engine side (drives request); slave: RAM side (drives ack/data).
interface mem_access_if;
  import mem_access_pkg::*;

  logic                   ram_en;
  logic [MEM_SEL_BUS-1:0] ram_write_en;
  logic [31:0]            ram_addr;
  logic [31:0]            ram_write_data;
  logic                   ram_ack;
  logic [31:0]            ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ack, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ack, ram_read_data
  );

endinterface

// File: rtl/mem_align_check.sv
// Lane-mask/offset legality check and store-data lane replication.
// in: sel, offset, data_in; out: aligned, data_rep.
module mem_align_check
  import mem_access_pkg::*;
(
  input  logic [MEM_SEL_BUS-1:0] sel,
  input  logic [1:0]             offset,
  input  logic [31:0]            data_in,
  output logic                   aligned,
  output logic [31:0]            data_rep
);

  logic is_byte;
  logic is_half;
  logic is_word;

  assign is_byte = sel inside {4'b0001, 4'b0010,
                               4'b0100, 4'b1000};
  assign is_half = sel inside {4'b0011, 4'b1100};
  assign is_word = sel == 4'b1111;

  always_comb begin
    aligned  = 1'b0;
    data_rep = '0;
    unique case (1'b1)
      is_byte: begin
        aligned  = sel == (4'b0001 << offset);
        data_rep = {4{data_in[7:0]}};
      end
      is_half: begin
        aligned  = (sel == 4'b0011 && offset == 2'd0)
                 | (sel == 4'b1100 && offset == 2'd2);
        data_rep = {2{data_in[15:0]}};
      end
      is_word: begin
        aligned  = offset == 2'd0;
        data_rep = data_in;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage memory-access engine: issues each load/store exactly once,
// stalls while the RAM is busy, holds/drains around stalls and flushes.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_current_stage,
  input  logic                   mem_read_flag_in,
  input  logic                   mem_write_flag_in,
  input  logic                   mem_sign_flag_in,
  input  logic [MEM_SEL_BUS-1:0] mem_sel_in,
  input  logic [31:0]            result_in,
  input  logic [31:0]            mem_write_data_in,
  mem_access_if.master           ram,
  output logic [31:0]            ram_read_data_out,
  output logic                   stall_request,
  output logic                   addr_error_load,
  output logic                   addr_error_store,
  output logic [31:0]            bad_vaddr,
  output logic                   bus_timeout
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_fsm_t    state_q;
  logic [7:0]  cnt_q;
  logic [31:0] hold_q;
  ram_req_t    req_q;
  ram_req_t    req_now;
  ram_req_t    req_out;

  logic        op;
  logic        aligned;
  logic        issue;
  logic        misaligned;
  logic        busy;
  logic        tmo_last;
  logic [31:0] data_rep;
  logic        unused_sign;

  // Sign extension happens in WB; the flag only travels with the instr.
  assign unused_sign = mem_sign_flag_in;

  mem_align_check u_align (
    .sel      (mem_sel_in),
    .offset   (result_in[1:0]),
    .data_in  (mem_write_data_in),
    .aligned  (aligned),
    .data_rep (data_rep)
  );

  assign op         = (mem_read_flag_in | mem_write_flag_in) & ~flush;
  assign issue      = op & aligned;
  assign misaligned = op & ~aligned;

  assign addr_error_load  = misaligned & mem_read_flag_in;
  assign addr_error_store = misaligned & mem_write_flag_in;
  assign bad_vaddr        = misaligned ? result_in : '0;

  assign req_now.write_en   = mem_write_flag_in ? mem_sel_in : '0;
  assign req_now.addr       = {result_in[31:2], 2'b00};
  assign req_now.write_data = data_rep;

  assign busy     = (state_q == MEM_WAIT) | (state_q == MEM_DRAIN);
  // Last ackless cycle of the budget: give up in this very cycle.
  assign tmo_last = busy & ~ram.ram_ack & (cnt_q == TMO_LAST);

  always_comb begin
    req_out           = '0;
    ram.ram_en        = 1'b0;
    ram_read_data_out = '0;
    stall_request     = 1'b0;
    bus_timeout       = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (issue) begin
          ram.ram_en = 1'b1;
          req_out    = req_now;
          if (ram.ram_ack) ram_read_data_out = ram.ram_read_data;
          else             stall_request     = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (tmo_last) begin
          bus_timeout = 1'b1;
        end else begin
          ram.ram_en = 1'b1;
          req_out    = req_q;
          if (ram.ram_ack) ram_read_data_out = ram.ram_read_data;
          else             stall_request     = 1'b1;
        end
      end
      MEM_HOLD: ram_read_data_out = hold_q;
      MEM_DRAIN: begin
        // A killed access still owns the bus; a new op must wait.
        stall_request = issue;
        if (tmo_last) begin
          bus_timeout = 1'b1;
        end else begin
          ram.ram_en = 1'b1;
          req_out    = req_q;
        end
      end
      default: ;
    endcase
  end

  assign ram.ram_write_en   = req_out.write_en;
  assign ram.ram_addr       = req_out.addr;
  assign ram.ram_write_data = req_out.write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        MEM_IDLE: begin
          if (issue) begin
            if (ram.ram_ack) begin
              if (stall_current_stage) begin
                state_q <= MEM_HOLD;
                hold_q  <= ram.ram_read_data;
              end
            end else begin
              state_q <= MEM_WAIT;
              cnt_q   <= '0;
              req_q   <= req_now;
            end
          end
        end
        MEM_WAIT: begin
          if (ram.ram_ack) begin
            if (!flush && stall_current_stage) begin
              state_q <= MEM_HOLD;
              hold_q  <= ram.ram_read_data;
            end else begin
              state_q <= MEM_IDLE;
            end
          end else if (tmo_last) begin
            state_q <= MEM_IDLE;
          end else if (flush) begin
            state_q <= MEM_DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        MEM_HOLD: begin
          if (flush | ~stall_current_stage) state_q <= MEM_IDLE;
        end
        MEM_DRAIN: begin
          if (ram.ram_ack | tmo_last) state_q <= MEM_IDLE;
          else                         cnt_q   <= cnt_q + 8'd1;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios with literal expectations,
// then randomized pipeline/RAM traffic against a transaction-level model.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        scs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        sgn = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rdo;
  logic [31:0] bva;
  logic        stq;
  logic        el;
  logic        es;
  logic        tmo;

  mem_access_if bus();

  mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .stall_current_stage (scs),
    .mem_read_flag_in    (rd),
    .mem_write_flag_in   (wr),
    .mem_sign_flag_in    (sgn),
    .mem_sel_in          (sel),
    .result_in           (addr),
    .mem_write_data_in   (wd),
    .ram                 (bus),
    .ram_read_data_out   (rdo),
    .stall_request       (stq),
    .addr_error_load     (el),
    .addr_error_store    (es),
    .bad_vaddr           (bva),
    .bus_timeout         (tmo)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: at most one access in flight, live or killed, or a held result.
  bit          m_pend = 0;
  bit          m_drain = 0;
  bit          m_held = 0;
  int          m_age = 0;
  logic [31:0] m_hold = '0;
  logic [3:0]  m_we = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wd = '0;

  logic        e_en, e_stall, e_el, e_es, e_tmo;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wd, e_rdo, e_bva;

  logic        s_en, s_stall, s_el, s_es, s_tmo;
  logic [3:0]  s_we;
  logic [31:0] s_addr, s_wd, s_rdo, s_bva;
  bit          last_scs = 0;

  function automatic bit legal(input logic [3:0] s, input logic [1:0] o);
    case ($countones(s))
      1: return s == 4'(1 << o);
      2: return o[0] == 1'b0 && s == 4'(3 << o);
      4: return o == 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rep(input logic [3:0] s,
                                      input logic [31:0] d);
    case ($countones(s))
      1: return 32'(d[7:0]) * 32'h0101_0101;
      2: return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic bit op_ok();
    return (rd | wr) && !flush && legal(sel, addr[1:0]);
  endfunction

  task automatic model_expect();
    bit op;
    bit last;
    op = (rd | wr) && !flush;
    {e_en, e_stall, e_el, e_es, e_tmo} = '0;
    {e_we, e_addr, e_wd, e_rdo, e_bva} = '0;
    if (op && !legal(sel, addr[1:0])) begin
      e_el  = rd;
      e_es  = wr;
      e_bva = addr;
    end
    if (m_pend || m_drain) begin
      last = (m_age == TMO - 1) && !bus.ram_ack;
      e_tmo = last;
      if (!last) begin
        e_en   = 1'b1;
        e_we   = m_we;
        e_addr = m_addr;
        e_wd   = m_wd;
      end
      if (m_pend && bus.ram_ack) e_rdo = bus.ram_read_data;
      e_stall = m_pend ? (!bus.ram_ack && !last) : op_ok();
    end else if (m_held) begin
      e_rdo = m_hold;
    end else if (op_ok()) begin
      e_en   = 1'b1;
      e_we   = wr ? sel : 4'h0;
      e_addr = addr & ~32'h3;
      e_wd   = rep(sel, wd);
      if (bus.ram_ack) e_rdo = bus.ram_read_data;
      else             e_stall = 1'b1;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_pend = 0; m_drain = 0; m_held = 0; m_age = 0;
    end else if (m_pend) begin
      if (bus.ram_ack) begin
        m_pend = 0;
        if (!flush && scs) begin
          m_held = 1; m_hold = bus.ram_read_data;
        end
      end else if (m_age == TMO - 1) begin
        m_pend = 0;
      end else if (flush) begin
        m_pend = 0; m_drain = 1; m_age = 0;
      end else begin
        m_age++;
      end
    end else if (m_drain) begin
      if (bus.ram_ack || m_age == TMO - 1) m_drain = 0;
      else m_age++;
    end else if (m_held) begin
      if (flush || !scs) m_held = 0;
    end else if (op_ok()) begin
      if (bus.ram_ack) begin
        if (scs) begin
          m_held = 1; m_hold = bus.ram_read_data;
        end
      end else begin
        m_pend = 1; m_age = 0;
        m_we = wr ? sel : 4'h0;
        m_addr = addr & ~32'h3;
        m_wd = rep(sel, wd);
      end
    end
  endtask

  // One pipeline cycle: drive, compare against model, advance model.
  task automatic step(input bit r, input bit rd_i, input bit wr_i,
                      input logic [3:0] sel_i, input logic [31:0] a_i,
                      input logic [31:0] wd_i, input bit fl, input bit ext,
                      input bit ack_i, input logic [31:0] rdat);
    logic [136:0] got;
    logic [136:0] want;
    rst = r; rd = rd_i; wr = wr_i; sel = sel_i; addr = a_i; wd = wd_i;
    flush = fl; sgn = 1'($urandom);
    bus.ram_ack = ack_i;
    bus.ram_read_data = rdat;
    model_expect();
    scs = e_stall | ext;
    @(negedge clk);
    s_en = bus.ram_en; s_we = bus.ram_write_en; s_addr = bus.ram_addr;
    s_wd = bus.ram_write_data; s_rdo = rdo; s_stall = stq;
    s_el = el; s_es = es; s_bva = bva; s_tmo = tmo;
    got  = {s_en, s_we, s_addr, s_wd, s_rdo, s_stall,
            s_el, s_es, s_bva, s_tmo};
    want = {e_en, e_we, e_addr, e_wd, e_rdo, e_stall,
            e_el, e_es, e_bva, e_tmo};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL cycle %0d outputs: got %h want %h", cyc, got, want);
    end
    last_scs = scs;
    model_update();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  bit          c_rd, c_wr;
  logic [3:0]  c_sel;
  logic [31:0] c_addr, c_wd;

  task automatic gen_instr();
    int k;
    int sz;
    logic [1:0] off;
    k = $urandom_range(0, 9);
    c_rd = k inside {[1:4]};
    c_wr = k inside {[5:8]};
    sz = $urandom_range(0, 2);
    if ($urandom_range(0, 9) != 0) begin
      case (sz)
        0: begin off = 2'($urandom); c_sel = 4'(1 << off); end
        1: begin off = 2'($urandom_range(0, 1) * 2); c_sel = 4'(3 << off); end
        default: begin off = 2'd0; c_sel = 4'hF; end
      endcase
    end else begin
      off = 2'($urandom);
      c_sel = 4'($urandom);
    end
    c_addr = ($urandom & ~32'h3) | 32'(off);
    c_wd = $urandom;
  endtask

  initial begin
    int nst;
    int nen;
    int ntmo;
    int tat;
    bit nxt;
    bus.ram_ack = 1'b0;
    bus.ram_read_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    idle(1);
    lit("reset_en", 32'(s_en), 0);
    lit("reset_rdo", s_rdo, 0);
    lit("reset_stall", 32'(s_stall), 0);

    // Zero-wait load word.
    step(0, 1, 0, 4'hF, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF);
    lit("zw_rdo", s_rdo, 32'hDEADBEEF);
    lit("zw_stall", 32'(s_stall), 0);
    lit("zw_addr", s_addr, 32'h100);

    // Three-cycle store byte.
    nst = 0; nen = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'b1000, 32'h103, 32'hAB, 0, 0, i == 2, 32'h0);
      nst += int'(s_stall); nen += int'(s_en);
      if (i == 0) begin
        lit("sb_we", 32'(s_we), 32'h8);
        lit("sb_wd", s_wd, 32'hABABABAB);
      end
    end
    lit("sb_stall_cycles", 32'(nst), 2);
    lit("sb_en_cycles", 32'(nen), 3);
    idle(1);
    lit("sb_no_reissue", 32'(s_en), 0);

    // Misaligned accesses.
    step(0, 1, 0, 4'hF, 32'h102, 0, 0, 0, 0, 32'h0);
    lit("mis_el", 32'(s_el), 1);
    lit("mis_bva", s_bva, 32'h102);
    lit("mis_en", 32'(s_en), 0);
    step(0, 0, 1, 4'b0011, 32'h101, 32'h1234, 0, 0, 0, 32'h0);
    lit("mis_es", 32'(s_es), 1);

    // External stall after ack: hold, no second request.
    step(0, 1, 0, 4'hF, 32'h200, 0, 0, 1, 1, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 4'hF, 32'h200, 0, 0, 1, 1, $urandom);
      lit("hold_rdo", s_rdo, 32'h12345678);
      lit("hold_en", 32'(s_en), 0);
    end
    step(0, 1, 0, 4'hF, 32'h200, 0, 0, 0, 0, 32'h0);
    lit("hold_exit_en", 32'(s_en), 0);
    idle(1);

    // Flush in WAIT, drain, then next load.
    step(0, 1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 32'h0);
    lit("fl_stall_issue", 32'(s_stall), 1);
    step(0, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0);
    lit("drain_stall", 32'(s_stall), 0);
    lit("drain_en", 32'(s_en), 1);
    lit("drain_addr", s_addr, 32'h300);
    step(0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'hBAD00BAD);
    lit("drain_discard", s_rdo, 0);
    step(0, 1, 0, 4'hF, 32'h304, 0, 0, 0, 1, 32'h5555AAAA);
    lit("post_drain_addr", s_addr, 32'h304);
    lit("post_drain_rdo", s_rdo, 32'h5555AAAA);

    // Timeout with no ack.
    ntmo = 0; tat = -1;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 4'hF, 32'h400, 0, 0, 0, 0, 32'h0);
      if (s_tmo) begin ntmo++; tat = i; end
      if (i == 4) begin
        lit("tmo_en", 32'(s_en), 0);
        lit("tmo_stall", 32'(s_stall), 0);
      end
    end
    idle(2);
    lit("tmo_pulses", 32'(ntmo), 1);
    lit("tmo_cycle", 32'(tat), 4);

    // Reset while waiting.
    step(0, 1, 0, 4'hF, 32'h500, 0, 0, 0, 0, 32'h0);
    step(1, 1, 0, 4'hF, 32'h500, 0, 0, 0, 0, 32'h0);
    idle(1);
    lit("rst_wait_en", 32'(s_en), 0);
    lit("rst_wait_stall", 32'(s_stall), 0);

    // Random pipeline traffic.
    nxt = 1;
    for (int n = 0; n < 4000; n++) begin
      bit fl;
      bit ext;
      bit ack;
      if (nxt) gen_instr();
      fl  = $urandom_range(0, 19) == 0;
      ext = $urandom_range(0, 4) == 0;
      ack = $urandom_range(0, 2) == 0;
      step(0, c_rd, c_wr, c_sel, c_addr, c_wd, fl, ext, ack, $urandom);
      nxt = fl || !last_scs;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
